uart_rx: RTL and testbench

//  UART receive deserialiser feeding the RX FIFO and uart_irq. It synchronises rx_i and

---
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receive deserialiser: synchronises the serial line, samples each bit mid-period
// and pushes completed 5-8 bit characters with parity/framing/overrun status pulses.
module uart_rx #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [1:0]       data_bits_i,
  input  logic             parity_en_i,
  input  logic             parity_even_i,
  input  logic             rx_i,
  input  logic             fifo_full_i,
  output logic             push_o,
  output logic [7:0]       data_o,
  output logic             pe_o,
  output logic             fe_o,
  output logic             ovr_o,
  output logic             busy_o
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BIDX_W  = 3;
  localparam int unsigned MIN_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state, state_nxt;
  logic                rx_m, rx_s, rx_p;
  logic [DIV_W-1:0]    cnt, cnt_nxt;
  logic [BIDX_W-1:0]   bidx, bidx_nxt;
  logic [DATA_W-1:0]   shift, shift_nxt;
  logic                par_err, par_err_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                push_nxt, pe_nxt, fe_nxt, ovr_nxt, busy_nxt;

  logic [DIV_W-1:0]    half_m1;
  logic [DIV_W-1:0]    div_m1;
  logic [BIDX_W-1:0]   last_idx;
  logic                cfg_ok;

  // Bit-timing thresholds derived from the divisor and the frame format.
  always_comb begin
    half_m1  = (div_i >> 1) - DIV_W'(1);
    div_m1   = div_i - DIV_W'(1);
    last_idx = BIDX_W'(4) + BIDX_W'(data_bits_i);
    cfg_ok   = en_i && (div_i >= DIV_W'(MIN_DIV));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bidx_nxt    = bidx;
    shift_nxt   = shift;
    par_err_nxt = par_err;
    data_nxt    = data_o;
    push_nxt    = 1'b0;
    pe_nxt      = 1'b0;
    fe_nxt      = 1'b0;
    ovr_nxt     = 1'b0;

    if (!cfg_ok) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      bidx_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          // Start needs a genuine 1->0 edge, so a held break never retriggers.
          if (rx_p && !rx_s) begin
            state_nxt = START;
          end
        end

        START: begin
          if (cnt >= half_m1) begin
            if (rx_s) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt   = DATA;
              cnt_nxt     = '0;
              bidx_nxt    = '0;
              shift_nxt   = '0;
              par_err_nxt = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + DIV_W'(1);
          end
        end

        DATA: begin
          if (cnt >= div_m1) begin
            cnt_nxt         = '0;
            shift_nxt[bidx] = rx_s;
            if (bidx >= last_idx) begin
              state_nxt = parity_en_i ? PARITY : STOP;
            end else begin
              bidx_nxt = bidx + BIDX_W'(1);
            end
          end else begin
            cnt_nxt = cnt + DIV_W'(1);
          end
        end

        PARITY: begin
          if (cnt >= div_m1) begin
            cnt_nxt     = '0;
            par_err_nxt = (^shift) ^ rx_s ^ ~parity_even_i;
            state_nxt   = STOP;
          end else begin
            cnt_nxt = cnt + DIV_W'(1);
          end
        end

        STOP: begin
          if (cnt >= div_m1) begin
            // Character is delivered even on errors; a full FIFO drops it.
            cnt_nxt   = '0;
            data_nxt  = shift;
            push_nxt  = !fifo_full_i;
            ovr_nxt   = fifo_full_i;
            pe_nxt    = parity_en_i && par_err;
            fe_nxt    = !rx_s;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + DIV_W'(1);
          end
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_p    <= 1'b1;
      cnt     <= '0;
      bidx    <= '0;
      shift   <= '0;
      par_err <= 1'b0;
      data_o  <= '0;
      push_o  <= 1'b0;
      pe_o    <= 1'b0;
      fe_o    <= 1'b0;
      ovr_o   <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rx_m    <= rx_i;
      rx_s    <= rx_m;
      rx_p    <= rx_s;
      cnt     <= cnt_nxt;
      bidx    <= bidx_nxt;
      shift   <= shift_nxt;
      par_err <= par_err_nxt;
      data_o  <= data_nxt;
      push_o  <= push_nxt;
      pe_o    <= pe_nxt;
      fe_o    <= fe_nxt;
      ovr_o   <= ovr_nxt;
      busy_o  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames scored through an expectation
// queue, plus hand-written glitch, break, abort and divisor-limit sequences.
module tb_uart_rx;

  localparam int unsigned DIV_W = 16;
  localparam int          NVEC  = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div;
  logic [1:0]       dbits;
  logic             par_en;
  logic             par_even;
  logic             rx;
  logic             full;
  logic             push;
  logic [7:0]       rx_data;
  logic             pe;
  logic             fe;
  logic             ovr;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_rx #(.DIV_W(DIV_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .div_i         (div),
    .data_bits_i   (dbits),
    .parity_en_i   (par_en),
    .parity_even_i (par_even),
    .rx_i          (rx),
    .fifo_full_i   (full),
    .push_o        (push),
    .data_o        (rx_data),
    .pe_o          (pe),
    .fe_o          (fe),
    .ovr_o         (ovr),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       push;
    logic       pe;
    logic       fe;
    logic       ovr;
    logic       chk_lat;
    int         start;
  } exp_t;

  typedef struct {
    int         gap;
    int         div;
    logic [1:0] dbits;
    logic       par_en;
    logic       par_even;
    logic       par_bit;
    logic       stop;
    logic       full;
    logic [7:0] din;
    logic [7:0] exp_data;
    logic       exp_push;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_ovr;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   lat;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every completion pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (push || pe || fe || ovr) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_completion: push=%b pe=%b fe=%b ovr=%b data=%h (cycle %0d)",
                 push, pe, fe, ovr, rx_data, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("push", 32'(push), 32'(mon_e.push));
        chk("data", 32'(rx_data), 32'(mon_e.data));
        chk("pe", 32'(pe), 32'(mon_e.pe));
        chk("fe", 32'(fe), 32'(mon_e.fe));
        chk("ovr", 32'(ovr), 32'(mon_e.ovr));
        if (mon_e.chk_lat) begin
          total++;
          lat = cyc - mon_e.start;
          if (lat < 148 || lat > 156) begin
            bad++;
            $display("FAIL latency: got %0d clks expected 148..156", lat);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic p, input logic e_pe,
                              input logic e_fe, input logic o, input logic lat_chk);
    exp_t e;
    e.data    = d;
    e.push    = p;
    e.pe      = e_pe;
    e.fe      = e_fe;
    e.ovr     = o;
    e.chk_lat = lat_chk;
    e.start   = cyc;
    sbq.push_back(e);
  endtask

  // Drives one frame; the line is left at the first stop-bit value.
  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input logic stop, input int nstop,
                            input logic exp_busy);
    int n;
    n = int'(div);
    hold(1'b0, n);
    chk("busy_mid_frame", 32'(busy), 32'(exp_busy));
    for (int i = 0; i < nbits; i++) hold(d[i], n);
    if (pen) hold(pbit, n);
    hold(stop, n);
    for (int i = 1; i < nstop; i++) hold(1'b1, n);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sbq.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic set_cfg(input int d, input logic [1:0] b, input logic pen, input logic pev);
    div      = DIV_W'(d);
    dbits    = b;
    par_en   = pen;
    par_even = pev;
  endtask

  initial begin
    //          gap div bits pen pev pbit stop full din    exp    push pe fe ovr
    vecs[0]  = '{20, 16, 2'd3, 0, 0, 0, 1, 0, 8'hA5, 8'hA5, 1, 0, 0, 0};
    vecs[1]  = '{20, 16, 2'd2, 1, 1, 1, 1, 0, 8'h55, 8'h55, 1, 1, 0, 0};
    vecs[2]  = '{20, 16, 2'd2, 1, 1, 0, 1, 0, 8'h55, 8'h55, 1, 0, 0, 0};
    vecs[3]  = '{20, 16, 2'd3, 0, 0, 0, 1, 1, 8'h81, 8'h81, 0, 0, 0, 1};
    vecs[4]  = '{ 0, 16, 2'd3, 0, 0, 0, 1, 0, 8'h5A, 8'h5A, 1, 0, 0, 0};
    vecs[5]  = '{20, 10, 2'd1, 1, 0, 1, 1, 0, 8'h2B, 8'h2B, 1, 0, 0, 0};
    vecs[6]  = '{20, 10, 2'd1, 1, 0, 0, 1, 0, 8'h2B, 8'h2B, 1, 1, 0, 0};
    vecs[7]  = '{20,  4, 2'd0, 0, 0, 0, 1, 0, 8'hFF, 8'h1F, 1, 0, 0, 0};
    vecs[8]  = '{20,  5, 2'd3, 1, 1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0};
    vecs[9]  = '{20,  7, 2'd3, 1, 0, 0, 1, 0, 8'hFF, 8'hFF, 1, 1, 0, 0};
    vecs[10] = '{20,  4, 2'd3, 0, 0, 0, 1, 0, 8'hC3, 8'hC3, 1, 0, 0, 0};
    vecs[11] = '{ 0,  4, 2'd3, 0, 0, 0, 1, 0, 8'h3C, 8'h3C, 1, 0, 0, 0};
    vecs[12] = '{20, 16, 2'd3, 1, 1, 1, 0, 0, 8'h96, 8'h96, 1, 1, 1, 0};
    vecs[13] = '{20, 16, 2'd2, 0, 0, 0, 1, 0, 8'hFF, 8'h7F, 1, 0, 0, 0};

    rst  = 1'b1;
    en   = 1'b0;
    rx   = 1'b1;
    full = 1'b0;
    set_cfg(16, 2'd3, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_pe", 32'(pe), 32'd0);
    chk("rst_fe", 32'(fe), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < NVEC; v++) begin
      if (vecs[v].gap > 0) begin
        rx = 1'b1;
        repeat (vecs[v].gap) @(negedge clk);
      end
      set_cfg(vecs[v].div, vecs[v].dbits, vecs[v].par_en, vecs[v].par_even);
      full = vecs[v].full;
      expect_frame(vecs[v].exp_data, vecs[v].exp_push, vecs[v].exp_pe, vecs[v].exp_fe,
                   vecs[v].exp_ovr, (v == 0) ? 1'b1 : 1'b0);
      send_frame(vecs[v].din, 5 + int'(vecs[v].dbits), vecs[v].par_en, vecs[v].par_bit,
                 vecs[v].stop, 1, 1'b1);
    end
    rx   = 1'b1;
    full = 1'b0;
    drain(64);

    // Glitch: a 3-clock low pulse is rejected at the mid-start sample.
    repeat (20) @(negedge clk);
    set_cfg(16, 2'd3, 1'b0, 1'b0);
    hold(1'b0, 3);
    rx = 1'b1;
    chk("glitch_busy", 32'(busy), 32'd1);
    begin
      int idle_at;
      idle_at = -1;
      for (int i = 0; i < 12 && idle_at < 0; i++) begin
        @(negedge clk);
        if (!busy) idle_at = i;
      end
      chk("glitch_idle", 32'(idle_at >= 0), 32'd1);
    end

    // Break: stop bit low then the line stays low; no retrigger until it returns high.
    repeat (20) @(negedge clk);
    expect_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    begin
      int busy_seen;
      busy_seen = 0;
      for (int i = 0; i < 40 * 16; i++) begin
        @(negedge clk);
        if (i > 16 && busy) busy_seen++;
      end
      chk("break_no_busy", 32'(busy_seen), 32'd0);
    end
    chk("break_fe_seen", 32'(sbq.size()), 32'd0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    expect_frame(8'hE7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE7, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    drain(64);

    // Reset during data bit 4 discards the frame; a 5N2 frame follows.
    repeat (20) @(negedge clk);
    hold(1'b0, 16);
    for (int i = 0; i < 4; i++) hold(1'b0, 16);
    hold(1'b1, 8);
    chk("abort_rst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rst_busy_after", 32'(busy), 32'd0);
    repeat (16 * 6) @(negedge clk);
    chk("abort_rst_stays_idle", 32'(busy), 32'd0);
    set_cfg(16, 2'd0, 1'b0, 1'b0);
    expect_frame(8'h1F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 2, 1'b1);
    drain(64);

    // Enable drop during data bit 4 behaves the same way.
    repeat (20) @(negedge clk);
    set_cfg(16, 2'd3, 1'b0, 1'b0);
    hold(1'b0, 16);
    for (int i = 0; i < 4; i++) hold(1'b0, 16);
    hold(1'b1, 8);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    chk("abort_en_busy_after", 32'(busy), 32'd0);
    repeat (16 * 6) @(negedge clk);
    expect_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    drain(64);

    // Divisor below 4 holds the receiver idle.
    repeat (20) @(negedge clk);
    set_cfg(3, 2'd3, 1'b0, 1'b0);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    repeat (20) @(negedge clk);
    chk("div3_idle", 32'(busy), 32'd0);

    drain(64);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
